ones_pattern_generator: RTL
===========================

Name: ones_pattern_generator

Overview:
- Inverse of the lab4 bit-counter datapath: accepts a ones-count N and builds a WIDTH-bit word containing exactly N ones.
- The ones form a thermometer code, shifted in serially one bit per clock from the LSB.
- Controller and datapath sit in one module and use the same s/done start-hold handshake as the counter, so the two blocks can be chained back-to-back in lab4 for round-trip checks.
- Also emits each generated bit serially for downstream consumers.

Parameters:
- WIDTH, 8, width of the generated pattern in bits (WIDTH >= 2).
- CW, 4, width of the count input N; CW must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- s  input  1  start; level-sensitive, held high by requester until done is seen.
- N  input  CW  requested number of ones; sampled only in S_IDLE.
- pattern  output  WIDTH  generated word; registered.
- bit_out  output  1  serial copy of the bit being shifted in this cycle (always 1 when bit_valid).
- bit_valid  output  1  high for each cycle in which a shift occurs.
- busy  output  1  high in S_GEN.
- done  output  1  high in S_DONE; pattern is final and stable.
- clamped  output  1  registered flag; set when the loaded N exceeded WIDTH.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - state <= S_IDLE; pattern <= 0; cnt <= 0; clamped <= 0.
  - All outputs read 0 while reset is low.
  - Reset mid-operation aborts immediately; there is no partial-result retention.
- Internal cnt register is CW bits wide.
- S_IDLE:
  - pattern <= 0 every cycle.
  - While s=0: cnt <= min(N, WIDTH), and clamped <= (N > WIDTH).
  - While s=1: cnt and clamped hold; ns = S_GEN.
  - The load therefore captures N on the last s=0 cycle, matching the counter's load_a rule.
  - busy=0, done=0, bit_valid=0.
- S_GEN:
  - If cnt != 0: pattern <= {pattern[WIDTH-2:0], 1'b1}; cnt <= cnt-1; bit_valid=1; bit_out=1 (combinational, this cycle); stay in S_GEN.
  - If cnt == 0: no shift; ns = S_DONE.
  - Changes on s or N during S_GEN are ignored; the operation always completes.
  - busy=1.
- S_DONE:
  - done=1; pattern, cnt and clamped hold.
  - s=0 -> S_IDLE; s=1 -> stay in S_DONE.
- Latency, with edge 0 as the edge that samples s=1 in S_IDLE:
  - Shifts occur on edges 1..K, where K = min(N, WIDTH).
  - done rises after edge K+1.
  - N=0: done after edge 1, pattern=0, bit_valid never asserts.
- Result invariant: in S_DONE, popcount(pattern) == K and pattern == (2**K)-1.
  - pattern == all ones when K == WIDTH.
- No arithmetic wrap is possible: cnt never decrements below 0, and the clamp keeps cnt <= WIDTH.
- Unreachable state encodings go to S_IDLE.

Test Plan:
- Reset check: pulse reset low mid-cycle with no clock edge → pattern=0, done=0, busy=0 immediately. Release, hold s=0 → stays in S_IDLE.
- Basic run: N=5, s=0 for 2 cycles, then s=1.
  - bit_valid high for exactly 5 cycles; pattern steps 01→03→07→0F→1F.
  - done after edge 6; hold s=1 3 more cycles → pattern stays 8'h1F.
  - Drop s → S_IDLE, pattern=0.
- Boundary counts:
  - N=0 → done after 1 edge, pattern=8'h00, bit_valid never high.
  - N=8 → pattern=8'hFF, done after edge 9, clamped=0.
- Clamp: N=4'hC → pattern=8'hFF, clamped=1, only 8 bit_valid pulses, done after edge 9.
- Input changes mid-operation: start with N=3, change N to 7 and drop s during S_GEN → still pattern=8'h07. done is observed in S_DONE (s already low), then S_IDLE is re-entered on the next edge.
- Reset mid-run: N=6, assert reset after 3 shifts (pattern=8'h07) → pattern=0 and state S_IDLE immediately. A new run with N=2 gives pattern=8'h03.

Source files
------------

// File: rtl/ones_pattern_generator_if.sv
// Purpose: request/result bundle for ones_pattern_generator (start/count in, pattern and status out).
// Latency: none, wires only.
// Backpressure: none; the requester holds s high until done, then drops it.
// Signals: s, N (requester-driven); pattern, bit_out, bit_valid, busy, done, clamped (generator-driven).
interface ones_pattern_generator_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             s;
  logic [CW-1:0]    N;
  logic [WIDTH-1:0] pattern;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic             clamped;

  // Requester side.
  modport master (
    output s, N,
    input  pattern, bit_out, bit_valid, busy, done, clamped
  );

  // Generator side.
  modport slave (
    input  s, N,
    output pattern, bit_out, bit_valid, busy, done, clamped
  );
endinterface

// File: rtl/ones_pattern_generator.sv
// Purpose: builds a WIDTH-bit thermometer word holding min(N, WIDTH) ones, shifted in one bit per clock from the LSB.
// Latency: K = min(N, WIDTH) shift cycles after the start edge, done one edge later (K+1 edges).
// Backpressure: s/done start-hold handshake; done holds until s drops, s/N are ignored while generating.
// Ports: clk; reset (async, active-low); bus.slave carrying s, N, pattern, bit_out, bit_valid, busy, done, clamped.
module ones_pattern_generator #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  ones_pattern_generator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_GEN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // WIDTH always fits in CW bits because 2**CW > WIDTH.
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pattern;
  logic             clamped;

  logic             n_over;
  logic [CW-1:0]    cnt_load;
  logic             cnt_nz;

  logic             busy_c;
  logic             done_c;
  logic             bit_valid_c;

  assign n_over   = (bus.N > WIDTH_C);
  assign cnt_load = n_over ? WIDTH_C : bus.N;
  assign cnt_nz   = (cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    bit_valid_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.s) state_nxt = S_GEN;
      end
      S_GEN: begin
        busy_c = 1'b1;
        if (cnt_nz) begin
          bit_valid_c = 1'b1;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_c = 1'b1;
        if (!bus.s) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern <= '0;
      cnt     <= '0;
      clamped <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          pattern <= '0;
          // Keep reloading while s is low so the last s=0 cycle wins.
          if (!bus.s) begin
            cnt     <= cnt_load;
            clamped <= n_over;
          end
        end
        S_GEN: begin
          if (cnt_nz) begin
            pattern <= {pattern[WIDTH-2:0], 1'b1};
            cnt     <= cnt - CW'(1);
          end
        end
        default: begin
          // S_DONE holds the result; stray encodings leave via state_nxt.
        end
      endcase
    end
  end

  assign bus.pattern   = pattern;
  assign bus.clamped   = clamped;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.bit_valid = bit_valid_c;
  // Every shifted-in bit is a one, so the serial copy equals the valid strobe.
  assign bus.bit_out   = bit_valid_c;

endmodule
